clk_div_bank: RTL and testbench

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_bank.sv | 162 ++++++++++++++++
 tb/tb_clk_div_bank.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank
//   Bank of NUM_CH independent programmable clock dividers. Each channel
//   counts system clocks and toggles its clk_out every D cycles, giving a
//   2*D-cycle output period. A one-cycle tick_out pulse marks every toggle.
//   New settings (D, start phase P, enable) go into a per-channel shadow
//   register. They move to the active set at the channel's next wrap, or at
//   once if the channel is stopped. A global sync strobe realigns all
//   channels and applies every pending shadow on the same edge.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   cfg_we     one-cycle write strobe for the shadow of channel cfg_ch
//   cfg_ch     channel index (values >= NUM_CH are ignored)
//   cfg_div    new divide value D (0 = halted)
//   cfg_phase  new start phase P (counter preload, 0 if P >= D)
//   cfg_en     new channel enable
//   sync       one-cycle realignment strobe for all channels
//   clk_out    per-channel divided clock
//   tick_out   per-channel one-cycle pulse on each clk_out toggle
//   cfg_pend   per-channel flag: shadow written, not yet applied
module clk_div_bank #(
    parameter int                NUM_CH  = 4,
    parameter int                DIV_W   = 8,
    parameter int                DEF_DIV = 10,
    parameter logic [NUM_CH-1:0] DEF_EN  = {NUM_CH{1'b1}},
    localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic              cfg_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] cfg_pend
);

    // Counter preload when a channel (re)starts: a phase outside the
    // period falls back to 0.
    function automatic logic [DIV_W-1:0] start_cnt(input logic [DIV_W-1:0] div,
                                                   input logic [DIV_W-1:0] phase);
        return (phase < div) ? phase : '0;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] act_div;
        logic [DIV_W-1:0] act_phase;
        logic             act_en;
        logic [DIV_W-1:0] sh_div;
        logic [DIV_W-1:0] sh_phase;
        logic             sh_en;
        logic             pend;
        logic [DIV_W-1:0] cnt;
        logic             clk_q;
        logic             tick_q;

        logic             wr;
        logic             running;
        logic             wrap;
        logic             xfer;
        logic             sync_take;
        logic [DIV_W-1:0] sync_div;
        logic [DIV_W-1:0] sync_phase;
        logic             sync_en;

        always_comb begin
            wr        = cfg_we && (cfg_ch == CH_W'(i));
            running   = act_en && (act_div != '0);
            wrap      = running && (cnt == act_div - DIV_W'(1));
            // A stopped channel has no wrap to wait for, so it takes the
            // shadow on the first edge after the write.
            xfer      = pend && (wrap || !running);
            // On sync, a write in the same cycle is already visible, so the
            // channel restarts directly with the freshly written values.
            sync_take  = wr || pend;
            sync_div   = act_div;
            sync_phase = act_phase;
            sync_en    = act_en;
            if (sync_take) begin
                sync_div   = wr ? cfg_div   : sh_div;
                sync_phase = wr ? cfg_phase : sh_phase;
                sync_en    = wr ? cfg_en    : sh_en;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                act_div   <= DIV_W'(DEF_DIV);
                act_phase <= '0;
                act_en    <= DEF_EN[i];
                sh_div    <= DIV_W'(DEF_DIV);
                sh_phase  <= '0;
                sh_en     <= DEF_EN[i];
                pend      <= 1'b0;
                cnt       <= '0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
            end else if (sync) begin
                if (wr) begin
                    sh_div   <= cfg_div;
                    sh_phase <= cfg_phase;
                    sh_en    <= cfg_en;
                end
                act_div   <= sync_div;
                act_phase <= sync_phase;
                act_en    <= sync_en;
                pend      <= 1'b0;
                cnt       <= sync_en ? start_cnt(sync_div, sync_phase) : '0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                if (wr) begin
                    sh_div   <= cfg_div;
                    sh_phase <= cfg_phase;
                    sh_en    <= cfg_en;
                end
                // A write landing on the transfer edge stays pending: the
                // old shadow is applied now, the new one at the next wrap.
                pend <= wr || (pend && !xfer);

                if (wrap) begin
                    cnt    <= '0;
                    clk_q  <= ~clk_q;
                    tick_q <= 1'b1;
                end else if (running) begin
                    cnt    <= cnt + DIV_W'(1);
                    tick_q <= 1'b0;
                end else if (!act_en) begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else begin
                    // Halted (D == 0): counter and clock frozen.
                    tick_q <= 1'b0;
                end

                // Transfer overrides the counter update above; clk_out keeps
                // its level unless the new setting disables the channel.
                if (xfer) begin
                    act_div   <= sh_div;
                    act_phase <= sh_phase;
                    act_en    <= sh_en;
                    if (sh_en) begin
                        cnt <= start_cnt(sh_div, sh_phase);
                    end else begin
                        cnt   <= '0;
                        clk_q <= 1'b0;
                    end
                end
            end
        end

        assign clk_out[i]  = clk_q;
        assign tick_out[i] = tick_q;
        assign cfg_pend[i] = pend;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank
//   Bench for clk_div_bank (4 channels, DIV_W 8, DEF_DIV 10). A stimulus
//   table drives config writes, sync and reset at fixed cycles and pushes
//   the expected tick times into a scoreboard queue; a check table holds
//   expected clk_out/tick_out/cfg_pend snapshots at fixed cycles.
//   Cycle t means the sample point just after the t-th edge following the
//   last initial reset edge.
module tb_clk_div_bank;
    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic       cfg_en;
    logic       sync;
    logic [3:0] clk_out;
    logic [3:0] tick_out;
    logic [3:0] cfg_pend;

    clk_div_bank #(
        .NUM_CH (4),
        .DIV_W  (8),
        .DEF_DIV(10),
        .DEF_EN (4'hF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
        .cfg_en   (cfg_en),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick_out (tick_out),
        .cfg_pend (cfg_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        bit         we;
        int         ch;
        int         dv;
        int         ph;
        bit         en;
        bit         sy;
        bit         rs;
        logic [3:0] emask;
        int         first;
        int         per;
        int         cnt;
    } stim_t;

    typedef struct {
        int         at;
        logic [3:0] cmask;
        logic [3:0] clk_exp;
        logic [3:0] tmask;
        logic [3:0] tick_exp;
        bit         pchk;
        logic [3:0] pend_exp;
    } chk_t;

    typedef struct {
        int t;
        int ch;
    } exp_t;

    stim_t stim[$];
    chk_t  chk[$];
    exp_t  sb[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    function automatic void add_stim(int at, bit we, int ch, int dv, int ph, bit en,
                                     bit sy, bit rs, logic [3:0] emask,
                                     int first, int per, int cnt);
        stim_t s;
        s = '{at, we, ch, dv, ph, en, sy, rs, emask, first, per, cnt};
        stim.push_back(s);
    endfunction

    function automatic void add_chk(int at, logic [3:0] cmask, logic [3:0] ce,
                                    logic [3:0] tmask, logic [3:0] te,
                                    bit pchk, logic [3:0] pe);
        chk_t c;
        c = '{at, cmask, ce, tmask, te, pchk, pe};
        chk.push_back(c);
    endfunction

    task automatic expect4(input string name, input int t, input logic [3:0] act,
                           input logic [3:0] exp, input logic [3:0] mask);
        n_assert++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %b, required %b (mask %b)", name, t, act, exp, mask);
        end
    endtask

    initial begin
        reset     = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        cfg_en    = 1'b0;
        sync      = 1'b0;

        // Stimulus: at, we, ch, D, P, EN, sync, reset, tick mask, first, period, count
        add_stim(  0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 10, 10, 2);
        add_stim( 25, 1, 1, 3, 0, 1, 0, 0, 4'b0010,  5,  3, 4);
        add_stim( 25, 0, 0, 0, 0, 0, 0, 0, 4'b1101,  5, 10, 2);
        add_stim( 45, 1, 2, 4, 2, 1, 0, 0, 4'b0000,  0,  0, 0);
        add_stim( 46, 1, 3, 4, 0, 1, 0, 0, 4'b0000,  0,  0, 0);
        add_stim( 47, 0, 0, 0, 0, 0, 1, 0, 4'b0100,  3,  4, 3);
        add_stim( 47, 0, 0, 0, 0, 0, 0, 0, 4'b1000,  5,  4, 3);
        add_stim( 47, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 11, 10, 1);
        add_stim( 47, 0, 0, 0, 0, 0, 0, 0, 4'b0010,  4,  3, 3);
        add_stim( 67, 1, 1, 5, 0, 1, 1, 0, 4'b0010,  6,  5, 2);
        add_stim( 67, 0, 0, 0, 0, 0, 0, 0, 4'b0100,  3,  4, 2);
        add_stim( 67, 0, 0, 0, 0, 0, 0, 0, 4'b1000,  5,  4, 2);
        add_stim( 67, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 11, 10, 1);
        add_stim( 80, 1, 0, 4, 0, 1, 0, 0, 4'b0000,  0,  0, 0);
        add_stim( 81, 0, 0, 0, 0, 0, 1, 0, 4'b1001,  5,  4, 4);
        add_stim(100, 1, 2, 0, 0, 1, 0, 0, 4'b0000,  0,  0, 0);
        add_stim(101, 1, 3, 4, 7, 1, 1, 0, 4'b1001,  5,  4, 2);
        add_stim(115, 1, 0, 4, 0, 0, 0, 0, 4'b0000,  0,  0, 0);
        add_stim(125, 1, 0, 1, 0, 1, 0, 0, 4'b0001,  3,  1, 5);
        add_stim(135, 1, 1, 7, 0, 1, 0, 0, 4'b0000,  0,  0, 0);
        add_stim(136, 1, 2, 3, 0, 1, 1, 1, 4'b0000,  0,  0, 0);
        add_stim(137, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 10, 10, 2);

        // Checks: at, clk mask, clk, tick mask, tick, check pend, pend
        add_chk(  0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0000);
        add_chk(  9, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 0, 4'b0000);
        add_chk( 10, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 0, 4'b0000);
        add_chk( 11, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000);
        add_chk( 19, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000);
        add_chk( 20, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0000);
        add_chk( 26, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0010);
        add_chk( 29, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0010);
        add_chk( 30, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0000);
        add_chk( 31, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 4'b0000);
        add_chk( 32, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 0, 4'b0000);
        add_chk( 33, 4'b1111, 4'b1101, 4'b1111, 4'b0010, 0, 4'b0000);
        add_chk( 36, 4'b1111, 4'b1111, 4'b1111, 4'b0010, 0, 4'b0000);
        add_chk( 40, 4'b1111, 4'b0000, 4'b1111, 4'b1101, 0, 4'b0000);
        add_chk( 46, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0100);
        add_chk( 47, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b1100);
        add_chk( 48, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0000);
        add_chk( 49, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 4'b0000);
        add_chk( 50, 4'b1111, 4'b0100, 4'b1111, 4'b0100, 0, 4'b0000);
        add_chk( 51, 4'b1111, 4'b0110, 4'b1111, 4'b0010, 0, 4'b0000);
        add_chk( 52, 4'b1111, 4'b1110, 4'b1111, 4'b1000, 0, 4'b0000);
        add_chk( 54, 4'b1111, 4'b1000, 4'b1111, 4'b0110, 0, 4'b0000);
        add_chk( 68, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0000);
        add_chk( 69, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 4'b0000);
        add_chk( 71, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 0, 4'b0000);
        add_chk( 81, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001);
        add_chk(101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0100);
        add_chk(102, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0000);
        add_chk(103, 4'b0100, 4'b0000, 4'b1100, 4'b0000, 0, 4'b0000);
        add_chk(105, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 4'b0000);
        add_chk(108, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 4'b0000);
        add_chk(112, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1, 4'b0000);
        add_chk(116, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001);
        add_chk(117, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001);
        add_chk(118, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
        add_chk(119, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000);
        add_chk(122, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000);
        add_chk(125, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000);
        add_chk(126, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001);
        add_chk(127, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1, 4'b0000);
        add_chk(128, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 4'b0000);
        add_chk(129, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 0, 4'b0000);
        add_chk(130, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 4'b0000);
        add_chk(136, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0010);
        add_chk(137, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0000);
        add_chk(138, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 0, 4'b0000);
        add_chk(146, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 0, 4'b0000);
        add_chk(147, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 0, 4'b0000);
        add_chk(148, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000);
        add_chk(157, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0000);

        // Initial reset held for three edges.
        repeat (3) @(posedge clk);
        #1;

        for (int t = 0; t <= 160; t++) begin
            // Snapshot checks due at this cycle.
            foreach (chk[k]) begin
                if (chk[k].at == t) begin
                    if (chk[k].cmask != 4'b0000)
                        expect4("clk_out", t, clk_out, chk[k].clk_exp, chk[k].cmask);
                    if (chk[k].tmask != 4'b0000)
                        expect4("tick_out", t, tick_out, chk[k].tick_exp, chk[k].tmask);
                    if (chk[k].pchk)
                        expect4("cfg_pend", t, cfg_pend, chk[k].pend_exp, 4'b1111);
                end
            end

            // Scoreboard: every tick due now must be present.
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].t == t) begin
                    n_assert++;
                    if (tick_out[sb[k].ch] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sb_tick ch%0d t=%0d: got %b, required 1",
                                 sb[k].ch, t, tick_out[sb[k].ch]);
                    end
                    sb.delete(k);
                end
            end

            // Equal D and P after sync: ch0 and ch3 must match bit-for-bit.
            if (t >= 82 && t <= 99) begin
                n_assert++;
                if (clk_out[0] !== clk_out[3]) begin
                    n_fail++;
                    $display("FAIL ch0_vs_ch3 t=%0d: got ch0=%b, required ch3=%b",
                             t, clk_out[0], clk_out[3]);
                end
            end

            // Drive this cycle's stimulus and queue its expected ticks.
            reset  = 1'b1;
            cfg_we = 1'b0;
            sync   = 1'b0;
            foreach (stim[k]) begin
                if (stim[k].at == t) begin
                    if (stim[k].we) begin
                        cfg_we    = 1'b1;
                        cfg_ch    = 2'(stim[k].ch);
                        cfg_div   = 8'(stim[k].dv);
                        cfg_phase = 8'(stim[k].ph);
                        cfg_en    = stim[k].en;
                    end
                    if (stim[k].sy) sync  = 1'b1;
                    if (stim[k].rs) reset = 1'b0;
                    for (int c = 0; c < 4; c++) begin
                        if (stim[k].emask[c]) begin
                            for (int n = 0; n < stim[k].cnt; n++) begin
                                exp_t e;
                                e.t  = t + stim[k].first + n * stim[k].per;
                                e.ch = c;
                                sb.push_back(e);
                            end
                        end
                    end
                end
            end

            @(posedge clk);
            #1;
        end

        // Any tick still queued never got checked.
        foreach (sb[k]) begin
            n_assert++;
            n_fail++;
            $display("FAIL sb_expired ch%0d: tick due at t=%0d never checked", sb[k].ch, sb[k].t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
